// File: rtl/mem_pkg.sv
// Shared types and defaults for the two-port cache-fill memory arbiter.
package mem_pkg;

  localparam int unsigned AddrWDefault = 28;
  localparam int unsigned LineWDefault = 128;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef enum logic {
    GntI = 1'b0,
    GntD = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus bundle; slave is the arbiter's view, master the environment's.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned LINE_W = LineWDefault
) ();

  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_mem_read, i_mem_addr,
    output i_mem_rdata, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_mem_read, i_mem_addr,
    input  i_mem_rdata, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie, grant the requester not granted last.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,  // [0] = I-cache, [1] = D-cache
  input  gnt_e       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == GntI) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache fills and D-cache fills/write-backs,
// one transaction at a time (IDLE -> BUSY -> RESP).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned LINE_W = LineWDefault
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  gnt_e              last_q, last_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        req, gnt;

  assign req = {bus.d_mem_read | bus.d_mem_write, bus.i_mem_read};

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt[1]) begin
          // A pending write-back goes out before a fill from the same D-cache request.
          last_d      = GntD;
          mem_write_d = bus.d_mem_write;
          mem_read_d  = ~bus.d_mem_write;
          mem_addr_d  = bus.d_mem_addr;
          if (bus.d_mem_write) begin
            mem_wdata_d = bus.d_mem_wdata;
          end
          state_d = StBusy;
        end else if (gnt[0]) begin
          last_d      = GntI;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.i_mem_addr;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (bus.mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StResp;
          // Only fills carry meaningful return data.
          if (mem_read_q) begin
            if (last_q == GntI) begin
              i_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= GntI;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_mem_rdata = i_rdata_q;
  assign bus.d_mem_rdata = d_rdata_q;
  assign bus.i_mem_ready = (state_q == StResp) && (last_q == GntI);
  assign bus.d_mem_ready = (state_q == StResp) && (last_q == GntD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, cache/memory agents, directed + random.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned AW = AddrWDefault;
  localparam int unsigned LW = LineWDefault;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .ADDR_W (AW),
    .LINE_W (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who was granted last, what each cache should hold, the open transaction.
  int          m_last;
  logic [LW-1:0] m_i_rdata, m_d_rdata;
  bit          txn_active;
  int          txn_who;  // 0 = I, 1 = D
  bit          txn_wr;
  logic [AW-1:0] txn_addr;
  logic [LW-1:0] txn_wdata, txn_rdata;
  int          cmd_first, rdy_cyc, resp_cyc, free_edge;

  // Cache agents and memory agent controls
  bit          i_req, d_rd, d_wr;
  logic [AW-1:0] i_addr_v, d_addr_v;
  logic [LW-1:0] d_wdata_v;
  bit          auto_req, hold_req, use_force_rdata;
  int          force_lat, spur_pct;
  logic [LW-1:0] force_rdata;

  // What the DUT was seen doing
  logic [AW:0] obs_log[$];
  bit          prev_cmd;
  int          i_rdy_cnt, d_rdy_cnt, cmd_cycles;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    bit cmd;
    cmd = bus.mem_read | bus.mem_write;
    if (cmd && !prev_cmd) obs_log.push_back({bus.mem_write, bus.mem_addr});
    prev_cmd = cmd;
    if (cmd) cmd_cycles++;
    if (bus.i_mem_ready) i_rdy_cnt++;
    if (bus.d_mem_ready) d_rdy_cnt++;
  endtask

  task automatic check_outputs();
    bit exp_cmd, resp_now;
    exp_cmd  = txn_active && (cyc >= cmd_first) && (cyc <= rdy_cyc);
    resp_now = txn_active && (cyc == resp_cyc);
    if (resp_now && !txn_wr) begin
      if (txn_who == 0) m_i_rdata = txn_rdata;
      else              m_d_rdata = txn_rdata;
    end
    chk("mem_read", LW'(bus.mem_read), LW'(exp_cmd && !txn_wr));
    chk("mem_write", LW'(bus.mem_write), LW'(exp_cmd && txn_wr));
    if (exp_cmd) begin
      chk("mem_addr", LW'(bus.mem_addr), LW'(txn_addr));
      if (txn_wr) chk("mem_wdata", bus.mem_wdata, txn_wdata);
    end
    chk("i_mem_ready", LW'(bus.i_mem_ready), LW'(resp_now && txn_who == 0));
    chk("d_mem_ready", LW'(bus.d_mem_ready), LW'(resp_now && txn_who == 1));
    chk("i_mem_rdata", bus.i_mem_rdata, m_i_rdata);
    chk("d_mem_rdata", bus.d_mem_rdata, m_d_rdata);
  endtask

  // Drive this cycle's inputs and, if the arbiter samples at the next edge, open a transaction.
  task automatic plan();
    bit pi, pd;
    if (auto_req) begin
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req    = 1'b1;
        i_addr_v = AW'($urandom());
      end
      if (!d_rd && !d_wr && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       d_rd = 1'b1;
          1:       d_wr = 1'b1;
          default: begin d_rd = 1'b1; d_wr = 1'b1; end
        endcase
        d_addr_v  = AW'($urandom());
        d_wdata_v = rand_line();
      end
    end
    bus.i_mem_read  = i_req;
    bus.i_mem_addr  = i_addr_v;
    bus.d_mem_read  = d_rd;
    bus.d_mem_write = d_wr;
    bus.d_mem_addr  = d_addr_v;
    bus.d_mem_wdata = d_wdata_v;

    if (txn_active && cyc == rdy_cyc) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = txn_rdata;
    end else if (!txn_active && $urandom_range(0, 99) < spur_pct) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rand_line();
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = rand_line();
    end

    pi = i_req;
    pd = d_rd || d_wr;
    if (!txn_active && cyc + 1 >= free_edge && (pi || pd)) begin
      if (pi && pd) txn_who = 1 - m_last;
      else          txn_who = pd ? 1 : 0;
      m_last    = txn_who;
      txn_wr    = (txn_who == 1) && d_wr;
      txn_addr  = (txn_who == 1) ? d_addr_v : i_addr_v;
      txn_wdata = d_wdata_v;
      txn_rdata = use_force_rdata ? force_rdata : rand_line();
      cmd_first = cyc + 1;
      rdy_cyc   = cmd_first + ((force_lat >= 0) ? force_lat : int'($urandom_range(0, 3)));
      resp_cyc  = rdy_cyc + 1;
      txn_active = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    observe();
    check_outputs();
    if (txn_active && cyc == resp_cyc) begin
      if (!hold_req) begin
        if (txn_who == 0)  i_req = 1'b0;
        else if (txn_wr)   d_wr  = 1'b0;
        else               d_rd  = 1'b0;
      end
      txn_active = 1'b0;
      free_edge  = cyc + 2;
    end
    plan();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_read", LW'(bus.mem_read), '0);
    chk("rst_mem_write", LW'(bus.mem_write), '0);
    chk("rst_mem_addr", LW'(bus.mem_addr), '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_i_ready", LW'(bus.i_mem_ready), '0);
    chk("rst_d_ready", LW'(bus.d_mem_ready), '0);
    chk("rst_i_rdata", bus.i_mem_rdata, '0);
    chk("rst_d_rdata", bus.d_mem_rdata, '0);
    txn_active    = 1'b0;
    m_last        = 0;
    m_i_rdata     = '0;
    m_d_rdata     = '0;
    prev_cmd      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst       = 1'b0;
    free_edge = cyc + 1;
    plan();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((txn_active || i_req || d_rd || d_wr) && n < 200) begin
      step();
      n++;
    end
    chk("drain_done", LW'(txn_active || i_req || d_rd || d_wr), '0);
  endtask

  task automatic clear_obs();
    obs_log.delete();
    i_rdy_cnt  = 0;
    d_rdy_cnt  = 0;
    cmd_cycles = 0;
  endtask

  initial begin
    logic [LW-1:0] a5;
    logic [AW:0]   exp_e;
    int            n;
    a5 = {16{8'hA5}};

    rst = 1'b1;
    i_req = 0; d_rd = 0; d_wr = 0;
    i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0;
    auto_req = 0; hold_req = 0; use_force_rdata = 0;
    force_lat = -1; spur_pct = 0; force_rdata = '0;
    bus.i_mem_read = 0; bus.i_mem_addr = '0;
    bus.d_mem_read = 0; bus.d_mem_write = 0; bus.d_mem_addr = '0; bus.d_mem_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single I-cache fill, memory answers three cycles after the command appears
    clear_obs();
    i_req = 1; i_addr_v = 28'h0000010;
    force_lat = 3; use_force_rdata = 1; force_rdata = a5;
    repeat (8) step();
    chk("t1_i_rdata", bus.i_mem_rdata, a5);
    chk("t1_cmd_cycles", LW'(cmd_cycles), LW'(4));
    chk("t1_i_ready_cnt", LW'(i_rdy_cnt), LW'(1));
    chk("t1_d_ready_cnt", LW'(d_rdy_cnt), LW'(0));
    chk("t1_d_rdata", bus.d_mem_rdata, '0);

    // Spurious mem_ready while idle
    clear_obs();
    use_force_rdata = 0;
    spur_pct = 100;
    repeat (6) step();
    spur_pct = 0;
    chk("t2_i_rdata_kept", bus.i_mem_rdata, a5);
    chk("t2_no_ready", LW'(i_rdy_cnt + d_rdy_cnt), LW'(0));

    // Simultaneous I and D reads after reset: D first
    do_reset();
    clear_obs();
    force_lat = -1;
    i_req = 1; i_addr_v = 28'h0000100;
    d_rd  = 1; d_addr_v = 28'h0000200;
    wait_idle();
    chk("t3_txn_count", LW'(obs_log.size()), LW'(2));
    if (obs_log.size() >= 2) begin
      exp_e = {1'b0, 28'h0000200};
      chk("t3_first_d", LW'(obs_log[0]), LW'(exp_e));
      exp_e = {1'b0, 28'h0000100};
      chk("t3_second_i", LW'(obs_log[1]), LW'(exp_e));
    end
    chk("t3_ready_cnt", LW'(i_rdy_cnt * 10 + d_rdy_cnt), LW'(11));

    // D write-back and fill together: write first
    clear_obs();
    d_rd = 1; d_wr = 1; d_addr_v = 28'h0000020; d_wdata_v = {8{16'h1234}};
    wait_idle();
    chk("t4_txn_count", LW'(obs_log.size()), LW'(2));
    if (obs_log.size() >= 2) begin
      exp_e = {1'b1, 28'h0000020};
      chk("t4_write_first", LW'(obs_log[0]), LW'(exp_e));
      exp_e = {1'b0, 28'h0000020};
      chk("t4_read_second", LW'(obs_log[1]), LW'(exp_e));
    end
    chk("t4_d_ready_cnt", LW'(d_rdy_cnt), LW'(2));

    // Both caches held continuously: grants alternate D, I, ...
    do_reset();
    clear_obs();
    hold_req = 1;
    i_req = 1; i_addr_v = 28'h0000111;
    d_rd  = 1; d_addr_v = 28'h0000222;
    n = 0;
    while (obs_log.size() < 6 && n < 100) begin
      step();
      n++;
    end
    hold_req = 0;
    chk("t5_enough_txns", LW'(obs_log.size() >= 6), LW'(1));
    for (int j = 0; j < 6 && j < obs_log.size(); j++) begin
      exp_e = (j % 2 == 0) ? {1'b0, 28'h0000222} : {1'b0, 28'h0000111};
      chk($sformatf("t5_grant%0d", j), LW'(obs_log[j]), LW'(exp_e));
    end
    wait_idle();

    // Reset in the middle of a D fill
    clear_obs();
    force_lat = 3;
    d_rd = 1; d_addr_v = 28'h0000333;
    repeat (3) step();
    chk("t6_busy_before_rst", LW'(bus.mem_read), LW'(1));
    do_reset();
    clear_obs();
    wait_idle();
    chk("t6_d_ready_once", LW'(d_rdy_cnt), LW'(1));
    chk("t6_txn_count", LW'(obs_log.size()), LW'(1));
    if (obs_log.size() >= 1) begin
      exp_e = {1'b0, 28'h0000333};
      chk("t6_reissued", LW'(obs_log[0]), LW'(exp_e));
    end

    // Random traffic with random latency and spurious mem_ready
    force_lat = -1;
    spur_pct  = 20;
    auto_req  = 1;
    repeat (400) step();
    auto_req = 0;
    wait_idle();
    spur_pct = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning memory line address width.
REQ-002 SHALL have parameter LINE_W, default 128, meaning cache line width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_mem_read  input  1  I-cache line-fill request, held until i_mem_ready.
REQ-006 SHALL have port i_mem_addr  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_mem_rdata  output  LINE_W  I-cache fill data.
REQ-008 SHALL have port i_mem_ready  output  1  one-cycle completion pulse to I-cache.
REQ-009 SHALL have port d_mem_read  input  1  D-cache line-fill request, held until d_mem_ready.
REQ-010 SHALL have port d_mem_write  input  1  D-cache write-back request, held until d_mem_ready.
REQ-011 SHALL have port d_mem_addr  input  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_mem_wdata  input  LINE_W  D-cache write-back data.
REQ-013 SHALL have port d_mem_rdata  output  LINE_W  D-cache fill data.
REQ-014 SHALL have port d_mem_ready  output  1  one-cycle completion pulse to D-cache.
REQ-015 SHALL have ports mem_read, mem_write  output  1 each  shared memory command.
REQ-016 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  LINE_W  shared memory address/data.
REQ-017 SHALL have ports mem_rdata  input  LINE_W, mem_ready  input  1  memory response, mem_ready one-cycle pulse.

Function
REQ-018 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; exactly one memory transaction outstanding.
REQ-019 IDLE: on any pending request SHALL select grantee, register command/addr/wdata, move to BUSY next edge; no request -> stay IDLE.
REQ-020 Selection SHALL be round-robin: both I and D pending -> grant the one not granted last; single requester -> grant it; last-grant flag resets to I (D wins first tie).
REQ-021 D side with d_mem_read and d_mem_write both high SHALL issue write first (one transaction); read served as a later transaction.
REQ-022 BUSY: mem_read/mem_write/mem_addr/mem_wdata SHALL be driven only from registers, stable for the whole BUSY state; first command cycle is one cycle after request sampled in IDLE.
REQ-023 BUSY with mem_ready=1 SHALL capture mem_rdata into the grantee's rdata register and move to RESP; non-grantee rdata unchanged.
REQ-024 RESP: grantee's *_mem_ready SHALL be 1 for exactly this one cycle, memory command low; then IDLE, so the requester's dropped request is never resampled.
REQ-025 Minimum request-to-ready latency SHALL be memory latency + 2 cycles (command at t+1, ready the cycle after mem_ready).
REQ-026 mem_ready in IDLE or RESP SHALL be ignored; mem_write transactions still wait for mem_ready.
REQ-027 *_mem_rdata SHALL hold last captured value until next fill to that requester.
REQ-028 mem_read and mem_write SHALL never be high together; both low outside BUSY.

Reset
REQ-029 rst high SHALL immediately force state IDLE, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i/d_mem_ready=0, i/d_mem_rdata=0, last-grant=I.
REQ-030 Reset during BUSY SHALL abandon the transaction; no ready pulse issued for it after reset release.
REQ-031 First request SHALL be sampled on the first rising edge with rst low.

Structure
REQ-032 State encoding (IDLE/BUSY/RESP), grantee encoding (GNT_I/GNT_D) and ADDR_W/LINE_W defaults SHALL live in shared package mem_pkg.
REQ-033 Round-robin selection SHALL be one sub-module rr_arb2 (2 requests, last-grant input, one-hot grant out); rest flat.

Verification
REQ-034 Only I read addr 0x0000010, memory returns 0xA5..A5 after 3 cycles -> mem_read high cycles 1-4, i_mem_ready pulse cycle 5, i_mem_rdata=0xA5..A5, d side untouched.
REQ-035 I read and D read asserted same cycle after reset -> D served first, I served second; no overlap of commands; each ready pulses once.
REQ-036 D read+write both high, addr 0x0000020, wdata 0x1234.. -> write transaction first (mem_write, mem_wdata=0x1234..), then read; two d_mem_ready pulses.
REQ-037 I and D held continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-038 rst asserted mid-BUSY of D read -> mem_read drops same cycle, no d_mem_ready after release, next request served normally.
REQ-039 Spurious mem_ready pulse in IDLE -> no ready pulses, rdata registers unchanged.
